// File: rtl/led_fader.sv
// led_fader: turns a binary LED target into a PWM "breathing" drive.
// Every edge of led_i becomes a linear brightness ramp of about FADE_MS
// milliseconds. The ramp can reverse mid-way and continues from the
// current level without jumping.
module led_fader #(
  parameter int unsigned FREQ     = 125_000_000,
  parameter int unsigned FADE_MS  = 250,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                led_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                busy_o
);

  localparam int unsigned MAX = (1 << PWM_BITS) - 1;

  // Clock cycles between brightness steps so that MAX steps span FADE_MS.
  // The arithmetic is done in 64 bits so that large clocks times long fades
  // cannot overflow.
  localparam longint unsigned TICKS_TOTAL = (64'(FREQ) / 64'd1000) * 64'(FADE_MS);
  localparam longint unsigned STEP_RAW    = TICKS_TOTAL / 64'(MAX);
  localparam longint unsigned STEP_DIV    = (STEP_RAW == 64'd0) ? 64'd1 : STEP_RAW;
  localparam int              DIV_W       = (STEP_DIV > 64'd1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(STEP_DIV - 64'd1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

  if (FREQ == 0) begin : g_bad_freq
    $error("led_fader: FREQ must be nonzero");
  end
  if (FADE_MS == 0) begin : g_bad_fade
    $error("led_fader: FADE_MS must be nonzero");
  end
  if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_bad_bits
    $error("led_fader: PWM_BITS must be in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    RISE    = 2'd1,
    IDLE_HI = 2'd2,
    FALL    = 2'd3
  } state_t;

  logic [1:0]          sync_q;
  logic                tgt;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  state_t              state;
  state_t              state_next;
  logic                busy_q;
  logic                led_q;

  assign tgt  = sync_q[1];
  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchroniser bringing the asynchronous target level into clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], led_i};
    end
  end

  // Free-running step divider; tick fires on its last count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Ramp FSM: reversal takes priority over a coincident step, and the level
  // saturates at both ends instead of wrapping.
  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      IDLE_LO: begin
        if (tgt) state_next = RISE;
      end
      IDLE_HI: begin
        if (!tgt) state_next = FALL;
      end
      RISE: begin
        if (!tgt) begin
          state_next = FALL;
        end else if (tick) begin
          if (level != LEVEL_MAX) level_next = level + ONE;
          if (level >= LEVEL_MAX - ONE) state_next = IDLE_HI;
        end
      end
      FALL: begin
        if (tgt) begin
          state_next = RISE;
        end else if (tick) begin
          if (level != '0) level_next = level - ONE;
          if (level <= ONE) state_next = IDLE_LO;
        end
      end
      default: begin
        state_next = IDLE_LO;
      end
    endcase
  end

  // State, level and busy registers; busy reflects the state being entered
  // so it rises on the same edge the ramp starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE_LO;
      level  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      busy_q <= (state_next == RISE) || (state_next == FALL);
    end
  end

  // PWM carrier counting 0..MAX-1 so level MAX gives a solid-on output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + ONE;
    end
  end

  // Registered PWM compare driving the LED pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q <= 1'b0;
    end else begin
      led_q <= (pwm_cnt < level);
    end
  end

  assign led_o   = led_q;
  assign level_o = level;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed self-checking bench for led_fader.
// Main instance: FREQ=15000, FADE_MS=2, PWM_BITS=4 -> MAX=15, STEP_DIV=2.
// A second slow instance (FADE_MS=200 -> STEP_DIV=200) holds its level long
// enough to measure the PWM duty cycle.
module tb_led_fader;

  localparam int MAX      = 15;
  localparam int STEP_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       led_in = 1'b0;
  logic       led_out;
  logic [3:0] level;
  logic       busy;

  logic       led_in_s = 1'b0;
  logic       led_out_s;
  logic [3:0] level_s;
  logic       busy_s;

  int checks = 0;
  int failures = 0;

  led_fader #(.FREQ(15000), .FADE_MS(2), .PWM_BITS(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .led_i   (led_in),
    .led_o   (led_out),
    .level_o (level),
    .busy_o  (busy)
  );

  led_fader #(.FREQ(15000), .FADE_MS(200), .PWM_BITS(4)) dut_slow (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .led_i   (led_in_s),
    .led_o   (led_out_s),
    .level_o (level_s),
    .busy_o  (busy_s)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    led_in = 1'b1;
    led_in_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      checks++;
      if ({led_out, level, busy} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle %0d: led=%b level=%0d busy=%b, required led=0 level=0 busy=0",
                 i, led_out, level, busy);
      end
    end
  endtask

  task automatic test_rise();
    int prev, since, nsteps, lv;
    bit first, bad_busy;
    led_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_cycle();
    checks++;
    if (level !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rise_idle: level=%0d busy=%b, required 0/0", level, busy);
    end
    led_in = 1'b1;
    step_cycle();
    step_cycle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rise_busy_early: busy=%b after 2 cycles, required 0", busy);
    end
    step_cycle();
    checks++;
    if (busy !== 1'b1 || level !== 4'd0) begin
      failures++;
      $display("[TB] FAIL rise_busy_latency: busy=%b level=%0d after 3 cycles, required 1/0", busy, level);
    end
    prev = 0; since = 0; nsteps = 0; first = 1'b1; bad_busy = 1'b0;
    for (int c = 0; c < 60 && level != 4'd15; c++) begin
      step_cycle();
      since++;
      lv = int'(level);
      if (lv != 15 && busy !== 1'b1) bad_busy = 1'b1;
      if (lv != prev) begin
        nsteps++;
        checks++;
        if (lv != prev + 1) begin
          failures++;
          $display("[TB] FAIL rise_step: level=%0d, required %0d", lv, prev + 1);
        end
        checks++;
        if (first ? (since > STEP_DIV) : (since != STEP_DIV)) begin
          failures++;
          $display("[TB] FAIL rise_interval: %0d cycles before level %0d, required %0d", since, lv, STEP_DIV);
        end
        first = 1'b0;
        since = 0;
        prev = lv;
      end
    end
    checks++;
    if (level !== 4'd15 || nsteps != MAX) begin
      failures++;
      $display("[TB] FAIL rise_final: level=%0d steps=%0d, required 15/15", level, nsteps);
    end
    checks++;
    if (busy !== 1'b0 || bad_busy) begin
      failures++;
      $display("[TB] FAIL rise_busy: busy_at_top=%b dropped_mid_ramp=%b, required 0/0", busy, bad_busy);
    end
    step_cycle();
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      if (led_out === 1'b1) nsteps++;
    end
    checks++;
    if (nsteps != 20) begin
      failures++;
      $display("[TB] FAIL rise_led_const: led high %0d of 20 cycles, required 20", nsteps);
    end
  endtask

  task automatic test_fall();
    int prev, since, nsteps, lv, ones;
    bit bad;
    led_in = 1'b0;
    step_cycle();
    step_cycle();
    checks++;
    if (busy !== 1'b0 || level !== 4'd15) begin
      failures++;
      $display("[TB] FAIL fall_busy_early: busy=%b level=%0d, required 0/15", busy, level);
    end
    step_cycle();
    checks++;
    if (busy !== 1'b1 || level !== 4'd15) begin
      failures++;
      $display("[TB] FAIL fall_busy_latency: busy=%b level=%0d, required 1/15", busy, level);
    end
    prev = 15; since = 0; nsteps = 0; bad = 1'b0;
    for (int c = 0; c < 60 && level != 4'd0; c++) begin
      step_cycle();
      since++;
      lv = int'(level);
      if (lv != prev) begin
        nsteps++;
        if (lv != prev - 1) bad = 1'b1;
        if (nsteps > 1 && since != STEP_DIV) bad = 1'b1;
        if (nsteps == 1 && since > STEP_DIV) bad = 1'b1;
        since = 0;
        prev = lv;
      end
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL fall_monotonic: irregular step seen, required -1 every %0d cycles", STEP_DIV);
    end
    checks++;
    if (level !== 4'd0 || nsteps != MAX || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fall_final: level=%0d steps=%0d busy=%b, required 0/15/0", level, nsteps, busy);
    end
    step_cycle();
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      if (led_out !== 1'b0) ones++;
    end
    checks++;
    if (ones != 0) begin
      failures++;
      $display("[TB] FAIL fall_led_const: led not low %0d of 20 cycles, required 0", ones);
    end
  endtask

  task automatic test_reversal();
    int prev, since, peak, ups, downs, lv;
    bit bad;
    led_in = 1'b1;
    for (int c = 0; c < 40 && level != 4'd7; c++) step_cycle();
    checks++;
    if (level !== 4'd7) begin
      failures++;
      $display("[TB] FAIL reversal_reach7: level=%0d, required 7", level);
    end
    led_in = 1'b0;
    prev = 7; since = 0; peak = 7; ups = 0; downs = 0; bad = 1'b0;
    for (int c = 0; c < 60 && level != 4'd0; c++) begin
      step_cycle();
      since++;
      lv = int'(level);
      if (lv > peak) peak = lv;
      if (lv != prev) begin
        if (lv == prev + 1) begin
          ups++;
          if (downs != 0) bad = 1'b1;
        end else if (lv == prev - 1) begin
          downs++;
        end else begin
          bad = 1'b1;
        end
        if (since != STEP_DIV) bad = 1'b1;
        since = 0;
        prev = lv;
      end
    end
    checks++;
    if (peak != 8) begin
      failures++;
      $display("[TB] FAIL reversal_peak: peak=%0d, required 8", peak);
    end
    checks++;
    if (bad || ups != 1 || downs != 8) begin
      failures++;
      $display("[TB] FAIL reversal_steps: ups=%0d downs=%0d irregular=%b, required 1/8/0", ups, downs, bad);
    end
    checks++;
    if (level !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reversal_final: level=%0d busy=%b, required 0/0", level, busy);
    end
  endtask

  task automatic test_duty();
    int ones;
    led_in_s = 1'b1;
    for (int c = 0; c < 2000 && level_s != 4'd5; c++) step_cycle();
    checks++;
    if (level_s !== 4'd5) begin
      failures++;
      $display("[TB] FAIL duty_reach5: level=%0d, required 5", level_s);
    end
    step_cycle();
    ones = 0;
    for (int i = 0; i < 15; i++) begin
      step_cycle();
      if (led_out_s === 1'b1) ones++;
    end
    checks++;
    if (ones != 5) begin
      failures++;
      $display("[TB] FAIL duty_count: led high %0d of 15 cycles, required 5", ones);
    end
    checks++;
    if (level_s !== 4'd5) begin
      failures++;
      $display("[TB] FAIL duty_frozen: level=%0d after window, required 5", level_s);
    end
  endtask

  task automatic test_async_reset();
    led_in = 1'b1;
    for (int c = 0; c < 50 && level != 4'd9; c++) step_cycle();
    checks++;
    if (level !== 4'd9) begin
      failures++;
      $display("[TB] FAIL async_reach9: level=%0d, required 9", level);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led_out, level, busy} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL async_clear: led=%b level=%0d busy=%b, required all 0 before next edge",
               led_out, level, busy);
    end
    checks++;
    if (level_s !== 4'd0 || busy_s !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_clear_slow: level=%0d busy=%b, required 0/0", level_s, busy_s);
    end
    step_cycle();
    step_cycle();
    rst_n = 1'b1;
    step_cycle();
    step_cycle();
    checks++;
    if (busy !== 1'b0 || level !== 4'd0) begin
      failures++;
      $display("[TB] FAIL restart_early: busy=%b level=%0d, required 0/0", busy, level);
    end
    step_cycle();
    checks++;
    if (busy !== 1'b1 || level !== 4'd0) begin
      failures++;
      $display("[TB] FAIL restart_busy: busy=%b level=%0d, required 1/0", busy, level);
    end
    for (int c = 0; c < STEP_DIV && level == 4'd0; c++) step_cycle();
    checks++;
    if (level !== 4'd1) begin
      failures++;
      $display("[TB] FAIL restart_first_step: level=%0d, required 1", level);
    end
  endtask

  // Sequence all scenarios, then report.
  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_reversal();
    test_duty();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Runaway guard.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
